run_ctrl: RTL
=============

RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 The block SHALL have parameter P0, default 1: RUN-mode enable period in clk cycles when speed_sel=0; legal range 1..2^32-1.
REQ-002 The block SHALL have parameter P1, default 1_000: enable period when speed_sel=1.
REQ-003 The block SHALL have parameter P2, default 1_000_000: enable period when speed_sel=2.
REQ-004 The block SHALL have parameter P3, default 50_000_000: enable period when speed_sel=3.
REQ-005 The block SHALL have parameter DEB_CYCLES, default 1_000_000: number of stable cycles a button must hold before it is accepted (debounce build only).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port run_btn, input, 1 bit: asynchronous button; each press toggles between HALT and RUN.
REQ-009 The block SHALL have port step_btn, input, 1 bit: asynchronous button; a press in HALT issues exactly one CPU enable.
REQ-010 The block SHALL have port speed_sel, input, 2 bits: selects the RUN period from P0..P3.
REQ-011 The block SHALL have port halt_req, input, 1 bit: synchronous halt request from the CPU, level-sensitive.
REQ-012 The block SHALL have port cpu_en, output, 1 bit: registered one-cycle CPU clock-enable pulse.
REQ-013 The block SHALL have port mode, output, 2 bits: current state, HALT=00, RUN=01, STEP=10.
REQ-014 The block SHALL have port en_count, output, 32 bits: total cpu_en pulses issued since reset.

Function
REQ-015 Button path: each button SHALL pass through a 2-flop synchronizer followed by a rising-edge detector, which produces a one-cycle press event.
REQ-016 FSM states SHALL be HALT, RUN and STEP; states 11 are unreachable and SHALL recover to HALT on the next cycle.
REQ-017 HALT -> RUN SHALL occur on a run press while halt_req=0; a run press while halt_req=1 SHALL be ignored.
REQ-018 HALT -> STEP SHALL occur on a step press while halt_req=0 and no run press occurs in the same cycle; a simultaneous run and step press SHALL select RUN.
REQ-019 STEP SHALL last exactly one cycle: cpu_en=1 in the cycle following entry to STEP, then the FSM returns to HALT.
REQ-020 RUN -> HALT SHALL occur on a run press or on halt_req=1; step presses in RUN SHALL be ignored.
REQ-021 Period counter: reset to 0 on entry to RUN; in RUN it increments each cycle and wraps to 0 at period-1.
REQ-022 At each wrap in RUN with halt_req=0, cpu_en SHALL be 1 in the next cycle, so the first pulse occurs exactly period cycles after entry to RUN.
REQ-023 halt_req=1 in the wrap cycle SHALL suppress that pulse.
REQ-024 speed_sel SHALL be sampled only at a wrap (and on RUN entry); a change mid-period takes effect for the following period.
REQ-025 Period 1 SHALL produce cpu_en=1 on every cycle while in RUN.
REQ-026 cpu_en SHALL never be high for two consecutive cycles except when the period is 1.
REQ-027 en_count SHALL increment by 1 in the same cycle that cpu_en=1, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 No cpu_en pulse SHALL be issued in HALT.

Reset
REQ-029 On rst=1 at a clock edge: mode=HALT, cpu_en=0, en_count=0, period counter=0, synchronizers and edge detectors cleared, debounce counters=0.
REQ-030 A reset asserted mid-RUN or in STEP SHALL abort any pending pulse, with cpu_en=0 in the cycle after the reset edge.
REQ-031 A button held high through reset release SHALL NOT generate a press event.

Configuration
REQ-032 Macro RUN_CTRL_DEBOUNCE_EN defined: each synchronized button must remain stable for DEB_CYCLES consecutive cycles before its filtered level updates; the edge detector operates on the filtered level.
REQ-033 Macro RUN_CTRL_DEBOUNCE_EN undefined: the edge detector operates directly on the synchronizer output, and a press event occurs 3 cycles after the input rises.

Verification (bench parameters: P0=1, P1=4, P2=10, P3=100, DEB_CYCLES=3)
REQ-034 Scenario 1: macro off; reset; step press; speed_sel=1 -> exactly one cpu_en pulse, mode returns to 00, en_count=1.
REQ-035 Scenario 2: run press with speed_sel=1 -> first cpu_en exactly 4 cycles after mode=01, then one pulse every 4 cycles; after 40 cycles en_count=10.
REQ-036 Scenario 3: in RUN, change speed_sel 1->2 mid-period -> the current 4-cycle period completes, then pulses occur every 10 cycles.
REQ-037 Scenario 4: in RUN, halt_req=1 on a wrap cycle -> no pulse, mode=00; a run press while halt_req=1 leaves mode=00.
REQ-038 Scenario 5: run and step pressed in the same cycle from HALT -> mode=01 and no STEP pulse; speed_sel=0 -> cpu_en high every cycle.
REQ-039 Scenario 6: macro on; 2-cycle glitch on step_btn -> no event; 5-cycle press -> one pulse; rst mid-RUN -> cpu_en=0 and en_count=0 on the next cycle.

Source files
------------

// File: rtl/run_ctrl.sv
// run_ctrl: HALT/RUN/STEP controller that issues one-cycle CPU clock-enable pulses.
// Define RUN_CTRL_DEBOUNCE_EN to insert a DEB_CYCLES stability filter on each button.
module run_ctrl #(
    parameter int unsigned P0         = 1,
    parameter int unsigned P1         = 1_000,
    parameter int unsigned P2         = 1_000_000,
    parameter int unsigned P3         = 50_000_000,
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_btn,
    input  logic        step_btn,
    input  logic [1:0]  speed_sel,
    input  logic        halt_req,
    output logic        cpu_en,
    output logic [1:0]  mode,
    output logic [31:0] en_count
);

    typedef enum logic [1:0] {
        StHalt = 2'b00,
        StRun  = 2'b01,
        StStep = 2'b10,
        StBad  = 2'b11
    } state_e;

    // Bit 0 is the run button, bit 1 the step button.
    logic [1:0] btn_raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] level;
    logic [1:0] prev_q;
    logic [1:0] armed_q;
    logic [1:0] press_q;
    logic [1:0] vld_q;

    logic run_press;
    logic step_press;

    assign btn_raw    = {step_btn, run_btn};
    assign run_press  = press_q[0];
    assign step_press = press_q[1];

    // A button only arms once a genuine post-reset low has been synchronized, so a
    // button held through reset release cannot produce a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            armed_q <= '0;
            press_q <= '0;
            vld_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= level;
            armed_q <= armed_q | ({2{vld_q[1]}} & ~sync2_q);
            press_q <= level & ~prev_q & armed_q;
            vld_q   <= {vld_q[0], 1'b1};
        end
    end

`ifdef RUN_CTRL_DEBOUNCE_EN
    localparam int unsigned DebW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);

    logic [DebW-1:0] deb_cnt_q [2];
    logic [1:0]      filt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DebLast) begin
                    filt_q[i]    <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + DebW'(1);
                end
            end
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    function automatic logic [31:0] sel_period(input logic [1:0] sel);
        logic [31:0] p;
        case (sel)
            2'd0:    p = 32'(P0);
            2'd1:    p = 32'(P1);
            2'd2:    p = 32'(P2);
            default: p = 32'(P3);
        endcase
        return p;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic        cpu_en_q, cpu_en_d;
    logic [31:0] en_count_q, en_count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StHalt;
            cnt_q      <= '0;
            period_q   <= 32'(P0);
            cpu_en_q   <= 1'b0;
            en_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            cpu_en_q   <= cpu_en_d;
            en_count_q <= en_count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        cpu_en_d = 1'b0;

        case (state_q)
            StHalt: begin
                cnt_d = '0;
                if (!halt_req) begin
                    if (run_press) begin
                        state_d  = StRun;
                        period_d = sel_period(speed_sel);
                    end else if (step_press) begin
                        state_d  = StStep;
                        cpu_en_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (run_press || halt_req) begin
                    state_d = StHalt;
                    cnt_d   = '0;
                end else if (cnt_q == period_q - 32'd1) begin
                    // Wrap: emit the pulse and pick up the next period's speed.
                    cnt_d    = '0;
                    period_d = sel_period(speed_sel);
                    cpu_en_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StStep: begin
                state_d = StHalt;
                cnt_d   = '0;
            end
            default: begin
                state_d = StHalt;
                cnt_d   = '0;
            end
        endcase
    end

    assign en_count_d = en_count_q + 32'(cpu_en_d);

    assign cpu_en   = cpu_en_q;
    assign mode     = state_q;
    assign en_count = en_count_q;

endmodule
